ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit inside the EX stage.
- Consumes the decoded instruction and operands registered by the ID/EX pipeline register.
- Captures the operands on acceptance and raises a hold request, which stalls IF/ID and makes the ID/EX register inject NOPs.
- Returns one 32-bit write-back result per accepted M-op.

---
 rtl/ex_muldiv.sv | 212 +++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use a shift-add loop and divides use a restoring loop; both take
// one bit per cycle. Division by zero and signed overflow finish without
// iterating. While an op is in flight the unit raises busy_o to hold the
// pipeline.
// Optional feature macro: MULDIV_SINGLE_CYCLE_MUL_EN. When it is defined, all
// four multiplies use a combinational multiplier and skip the iteration loop.

module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [31:0]       inst_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        reg_waddr_o,
    output logic              reg_wen_o
);

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic                sign1_q, sign2_q;
    logic [DATA_W-1:0]   a_q;          // multiplicand, or dividend shifting out MSB-first
    logic [DATA_W-1:0]   b_q;          // multiplier shifting out LSB-first, or divisor
    logic [2*DATA_W-1:0] acc_q;        // product, or {remainder, quotient}
    logic [CNT_W-1:0]    cnt_q;
    logic                spec_q;
    logic [DATA_W-1:0]   spec_res_q;
    logic [DATA_W-1:0]   result_q;
    logic [4:0]          waddr_q;

    logic              m_op;
    logic [2:0]        funct3;
    logic              sign1_d, sign2_d;
    logic [DATA_W-1:0] abs1, abs2;
    logic              special;
    logic [DATA_W-1:0] spec_res_d;

    // Decode the incoming instruction and prepare the operand magnitudes and signs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        m_op       = 1'b0;
        funct3     = inst_i[14:12];
        sign1_d    = 1'b0;
        sign2_d    = 1'b0;
        special    = 1'b0;
        spec_res_d = '0;

        m_op = (inst_i[6:0] == OPC_OP) && (inst_i[31:25] == FUNCT7_M);
        // MULH, MULHSU, DIV and REM treat op1 as signed; MULH, DIV and REM also op2.
        sign1_d = op1_i[DATA_W-1] && (funct3 == 3'b001 || funct3 == 3'b010 ||
                                      funct3 == 3'b100 || funct3 == 3'b110);
        sign2_d = op2_i[DATA_W-1] && (funct3 == 3'b001 || funct3 == 3'b100 ||
                                      funct3 == 3'b110);

        if (funct3[2] && op2_i == '0) begin
            special    = 1'b1;
            spec_res_d = funct3[1] ? op1_i : '1;
        end else if (funct3[2] && !funct3[0] &&
                     op1_i == {1'b1, {(DATA_W-1){1'b0}}} && op2_i == '1) begin
            special    = 1'b1;
            spec_res_d = funct3[1] ? '0 : op1_i;
        end
    end

    assign abs1 = sign1_d ? -op1_i : op1_i;
    assign abs2 = sign2_d ? -op2_i : op2_i;

    // One shift-add multiply step.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // One restoring divide step: try to subtract the divisor from the shifted remainder.
    logic [DATA_W+1:0]   div_trial;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem_next;
    logic [2*DATA_W-1:0] div_next;
    assign div_trial    = {1'b0, acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]} - {2'b00, b_q};
    assign div_ge       = ~div_trial[DATA_W+1];
    assign div_rem_next = div_ge ? div_trial[DATA_W-1:0]
                                 : {acc_q[2*DATA_W-2:DATA_W], a_q[DATA_W-1]};
    assign div_next     = {div_rem_next, acc_q[DATA_W-2:0], div_ge};

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*DATA_W-1:0] mul_full;
    assign mul_full = {{DATA_W{1'b0}}, abs1} * {{DATA_W{1'b0}}, abs2};
`endif

    // Bits never consulted: register fields of inst_i and the trial-difference bit
    // that cannot be set once the remainder is known to be below the divisor.
    logic unused_bits;
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7], div_trial[DATA_W]};

    // Sign fix-up and result selection for the op completing in DONE.
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot, rem, final_res;
    assign prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    assign quot = (sign1_q ^ sign2_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem  = sign1_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    // Select the write-back word from the fixed-up product, quotient or remainder.
    always_comb begin
        final_res = prod[DATA_W-1:0];
        if (spec_q) begin
            final_res = spec_res_q;
        end else begin
            case (funct3_q)
                3'b000:                 final_res = prod[DATA_W-1:0];
                3'b001, 3'b010, 3'b011: final_res = prod[2*DATA_W-1:DATA_W];
                3'b100, 3'b101:         final_res = quot;
                default:                final_res = rem;
            endcase
        end
    end

    // Control FSM plus operand, accumulator and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n_i) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            rd_q       <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
            waddr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_op && !flush_i) begin
                        funct3_q   <= funct3;
                        rd_q       <= reg_waddr_i;
                        sign1_q    <= sign1_d;
                        sign2_q    <= sign2_d;
                        a_q        <= abs1;
                        b_q        <= abs2;
                        acc_q      <= '0;
                        cnt_q      <= CNT_W'(DATA_W);
                        spec_q     <= special;
                        spec_res_q <= spec_res_d;
                        if (special) begin
                            state_q <= DONE;
                        end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                        else if (!funct3[2]) begin
                            acc_q   <= mul_full;
                            state_q <= DONE;
                        end
`endif
                        else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        if (funct3_q[2]) begin
                            acc_q <= div_next;
                            a_q   <= a_q << 1;
                        end else begin
                            acc_q <= mul_next;
                            b_q   <= b_q >> 1;
                        end
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!flush_i) begin
                        result_q <= final_res;
                        waddr_q  <= rd_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = (state_q == IDLE && m_op && !flush_i) || state_q == CALC;
    assign result_valid_o = (state_q == DONE) && !flush_i;
    assign reg_wen_o      = result_valid_o;
    assign result_o       = result_valid_o ? final_res : result_q;
    assign reg_waddr_o    = result_valid_o ? rd_q : waddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an
// arithmetic reference model (result value, latency, busy and strobe timing).

module tb_ex_muldiv;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] inst_i = NOP;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_wen_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_result = '0;

    ex_muldiv dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .inst_i         (inst_i),
        .op1_i          (op1_i),
        .op2_i          (op2_i),
        .reg_waddr_i    (reg_waddr_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wen_o      (reg_wen_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Present new inputs at the first negedge, then step until a strobe or a cycle budget.
    task automatic wait_strobe(input logic [31:0] nxt_inst, input logic [4:0] nxt_waddr,
                               input logic [31:0] nxt_op1, input logic [31:0] nxt_op2,
                               output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk_i);
            if (n == 0) begin
                inst_i      = nxt_inst;
                reg_waddr_i = nxt_waddr;
                op1_i       = nxt_op1;
                op2_i       = nxt_op2;
            end
            #1;
            n++;
            if (!result_valid_o) nbusy += int'(busy_o);
        end while (!result_valid_o && n < 100);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp_res;
        int          lat, n, nb;
        exp_res = ref_model(f3, a, b);
        lat     = exp_latency(f3, a, b);
        @(negedge clk_i);
        inst_i = mk_inst(f3, rd);
        op1_i = a;
        op2_i = b;
        reg_waddr_i = rd;
        #1;
        check({tag, " busy@accept"}, 32'(busy_o), 32'd1);
        wait_strobe(NOP, ~rd, $urandom, $urandom, n, nb);
        check({tag, " latency"}, n, lat);
        check({tag, " busy cycles"}, 1 + nb, lat);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " rd"}, 32'(reg_waddr_o), 32'(rd));
        check({tag, " wen"}, 32'(reg_wen_o), 32'd1);
        check({tag, " busy@done"}, 32'(busy_o), 32'd0);
        last_result = exp_res;
        @(negedge clk_i);
        #1;
        check({tag, " strobe width"}, 32'(result_valid_o), 32'd0);
        check({tag, " result hold"}, result_o, last_result);
    endtask

    initial begin
        int n, nb, strobes, busy_seen;

        // Reset state.
        #12;
        check("reset valid", 32'(result_valid_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset rd", 32'(reg_waddr_o), 32'd0);
        check("reset wen", 32'(reg_wen_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Directed arithmetic cases.
        run_op("MUL 7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op("MULHU -1x-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        run_op("MULH -1x-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        run_op("MULHSU -1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);
        run_op("DIV -20/3", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10);
        run_op("REM -20/3", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd11);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd12);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd13);
        run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd14);
        run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 5'd15);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);

        // Flush during CALC at A+10.
        @(negedge clk_i);
        inst_i = mk_inst(3'd5, 5'd20);
        op1_i = 32'd1000;
        op2_i = 32'd7;
        reg_waddr_i = 5'd20;
        @(negedge clk_i);
        inst_i = NOP;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        check("flush calc valid", 32'(result_valid_o), 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("flush calc busy", 32'(busy_o), 32'd0);
        check("flush calc result hold", result_o, last_result);
        strobes = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            #1;
            strobes += int'(result_valid_o);
            busy_seen += int'(busy_o);
        end
        check("flush calc strobes", strobes, 0);
        check("flush calc idle", busy_seen, 0);
        run_op("MUL 2x3 after flush", 3'd0, 32'd2, 32'd3, 5'd9);

        // Flush in the DONE cycle of a special-case divide.
        @(negedge clk_i);
        inst_i = mk_inst(3'd4, 5'd21);
        op1_i = 32'd5;
        op2_i = 32'd0;
        reg_waddr_i = 5'd21;
        @(negedge clk_i);
        inst_i = NOP;
        flush_i = 1'b1;
        #1;
        check("flush done valid", 32'(result_valid_o), 32'd0);
        check("flush done wen", 32'(reg_wen_o), 32'd0);
        check("flush done result hold", result_o, last_result);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("flush done after valid", 32'(result_valid_o), 32'd0);
        check("flush done after result", result_o, last_result);

        // Asynchronous reset at A+5 of a MUL.
        @(negedge clk_i);
        inst_i = mk_inst(3'd0, 5'd5);
        op1_i = 32'd7;
        op2_i = 32'hFFFF_FFFD;
        reg_waddr_i = 5'd5;
        @(negedge clk_i);
        inst_i = NOP;
        repeat (4) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst valid", 32'(result_valid_o), 32'd0);
        check("async rst result", result_o, 32'd0);
        check("async rst rd", 32'(reg_waddr_o), 32'd0);
        check("async rst wen", 32'(reg_wen_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        last_result = '0;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            #1;
            strobes += int'(result_valid_o);
        end
        check("post rst strobes", strobes, 0);

        // Back-to-back: second op held on inst_i is accepted the cycle after DONE.
        @(negedge clk_i);
        inst_i = mk_inst(3'd5, 5'd1);
        op1_i = 32'd100;
        op2_i = 32'd7;
        reg_waddr_i = 5'd1;
        #1;
        check("b2b first busy@accept", 32'(busy_o), 32'd1);
        wait_strobe(mk_inst(3'd7, 5'd2), 5'd2, 32'd100, 32'd7, n, nb);
        check("b2b first latency", n, 33);
        check("b2b first result", result_o, 32'd14);
        check("b2b first rd", 32'(reg_waddr_o), 32'd1);
        check("b2b busy@done", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("b2b second accept busy", 32'(busy_o), 32'd1);
        check("b2b gap valid", 32'(result_valid_o), 32'd0);
        wait_strobe(NOP, 5'd0, 32'd0, 32'd0, n, nb);
        check("b2b second latency", n, 33);
        check("b2b second result", result_o, 32'd2);
        check("b2b second rd", 32'(reg_waddr_o), 32'd2);
        last_result = 32'd2;

        // Randomized ops against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b,
                   5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
